// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the 5-stage CPU pipeline control
// Purpose: PC source encodings decoded in ID and the hazard controller FSM
// state encoding. No ports; imported with import cpu_pkg::*.
package cpu_pkg;

    localparam logic [2:0] PC_SEQ   = 3'd0;
    localparam logic [2:0] PC_BR    = 3'd1;
    localparam logic [2:0] PC_J     = 3'd2;
    localparam logic [2:0] PC_JR    = 3'd3;
    localparam logic [2:0] PC_ILLOP = 3'd4;
    localparam logic [2:0] PC_XADR  = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_TOUT    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - pair of wrapping event counters with enables
// Purpose: two independent free-running counters that wrap modulo 2^W.
// Ports:
//   clk, reset (async, active-low)
//   en_a, en_b   : increment the matching counter this cycle
//   cnt_a, cnt_b : current counter values
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_a,
    input  logic         en_b,
    output logic [W-1:0] cnt_a,
    output logic [W-1:0] cnt_b
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (en_a) cnt_a <= cnt_a + 1'b1;
            if (en_b) cnt_b <= cnt_b + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, flush and memory-wait controller
// Purpose: selects stall/flush/freeze controls for the 5-stage pipeline,
// tracks multi-cycle data-memory waits with a watchdog, and counts
// load-use bubbles and branch/jump/exception flushes.
// Ports:
//   clk, reset (async, active-low)
//   Rs_ID, Rt_ID, PCSrc_ID           : instruction currently in ID
//   MemRd_ID_EX, Rt_ID_EX, PCSrc_ID_EX, ALUOut0_EX : instruction in EX
//   mem_req, mem_ready               : EX/MEM data memory handshake
//   PC_write, IF_ID_write            : 1 = register advances
//   IF_ID_flush, ID_EX_flush         : zero the stage register
//   pipe_freeze                      : hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout                      : sticky watchdog flag
//   stall_cnt, flush_cnt             : performance counters
//   state                            : FSM state for debug
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic [2:0]       PCSrc_ID,
    input  logic             MemRd_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [2:0]       PCSrc_ID_EX,
    input  logic             ALUOut0_EX,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam int WCNT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    hz_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_d;
    logic              tout_set;
    logic              freeze, br_taken, load_use, jump;
    logic              stall_en, flush_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
            if (tout_set) mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt;
        tout_set    = 1'b0;
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_freeze = 1'b0;
        stall_en    = 1'b0;
        flush_en    = 1'b0;

        // A memory access that does not complete this cycle freezes the
        // pipe even before the FSM has left RUN.
        freeze   = (state_q != ST_RUN) | (mem_req & ~mem_ready);
        br_taken = (PCSrc_ID_EX == PC_BR) & ALUOut0_EX;
        // $0 is never a real dependency, so loads into it never stall.
        load_use = MemRd_ID_EX & (Rt_ID_EX != 5'd0) &
                   ((Rt_ID_EX == Rs_ID) | (Rt_ID_EX == Rt_ID));
        case (PCSrc_ID)
            PC_J, PC_JR, PC_ILLOP, PC_XADR: jump = 1'b1;
            PC_SEQ, PC_BR:                  jump = 1'b0;
            default:                        jump = 1'b0;
        endcase

        case (state_q)
            ST_RUN: begin
                if (mem_req & ~mem_ready) begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEMWAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d  = ST_TOUT;
                    tout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            ST_TOUT: begin
                // Wait counter holds at its last value here.
                if (mem_ready) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Controls are forced to their RUN/no-hazard values in reset so the
        // pipeline sees a clean idle state regardless of the inputs.
        if (reset) begin
            if (freeze) begin
                pipe_freeze = 1'b1;
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
            end else if (br_taken) begin
                // The dependent instruction in ID is squashed, so a
                // simultaneous load-use never costs a bubble.
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                flush_en    = 1'b1;
            end else if (load_use) begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
                stall_en    = 1'b1;
            end else if (jump) begin
                IF_ID_flush = 1'b1;
                flush_en    = 1'b1;
            end
        end
    end

    assign state = state_q;

    hazard_perf_cnt #(
        .W (CNT_W)
    ) u_perf_cnt (
        .clk   (clk),
        .reset (reset),
        .en_a  (stall_en),
        .en_b  (flush_en),
        .cnt_a (stall_cnt),
        .cnt_b (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 8;

    localparam logic [4:0] C_N = 5'b11000;
    localparam logic [4:0] C_S = 5'b00010;
    localparam logic [4:0] C_B = 5'b11110;
    localparam logic [4:0] C_J = 5'b11100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] Rs_ID = '0, Rt_ID = '0, Rt_ID_EX = '0;
    logic [2:0] PCSrc_ID = '0, PCSrc_ID_EX = '0;
    logic MemRd_ID_EX = 1'b0, ALUOut0_EX = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0] state;
    logic [4:0] ctl;

    assign ctl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze};

    hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .PCSrc_ID(PCSrc_ID),
        .MemRd_ID_EX(MemRd_ID_EX), .Rt_ID_EX(Rt_ID_EX),
        .PCSrc_ID_EX(PCSrc_ID_EX), .ALUOut0_EX(ALUOut0_EX),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic [2:0] pid;
        logic       memrd;
        logic [4:0] rtex;
        logic [2:0] pex;
        logic       alu, mreq, mrdy;
        logic [4:0] exp_ctl;
        int         exp_stall, exp_flush;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state as a plain number, wait measured as elapsed
    // cycles spent waiting, counters as unbounded integers.
    int m_state, m_waited, m_tout, m_stall, m_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int rs, rt, pid, memrd, rtex, pex, alu, mreq, mrdy,
                                input logic [4:0] c, input int s, f);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.pid = 3'(pid); v.memrd = 1'(memrd);
        v.rtex = 5'(rtex); v.pex = 3'(pex); v.alu = 1'(alu);
        v.mreq = 1'(mreq); v.mrdy = 1'(mrdy);
        v.exp_ctl = c; v.exp_stall = s; v.exp_flush = f;
        return v;
    endfunction

    function automatic int m_freeze();
        return (m_state != 0 || (mem_req && !mem_ready)) ? 1 : 0;
    endfunction

    function automatic int m_rule();
        // 1 freeze, 2 branch, 3 load-use, 4 jump, 5 none
        if (m_freeze() != 0) return 1;
        if (PCSrc_ID_EX == 3'd1 && ALUOut0_EX) return 2;
        if (MemRd_ID_EX && Rt_ID_EX != 0 && (Rt_ID_EX == Rs_ID || Rt_ID_EX == Rt_ID)) return 3;
        if (PCSrc_ID >= 3'd2 && PCSrc_ID <= 3'd5) return 4;
        return 5;
    endfunction

    function automatic logic [4:0] m_ctl();
        case (m_rule())
            1: return 5'b00001;
            2: return C_B;
            3: return C_S;
            4: return C_J;
            default: return C_N;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_waited = 0; m_tout = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_edge();
        int r;
        r = m_rule();
        if (r == 2 || r == 4) m_flush++;
        if (r == 3) m_stall++;
        case (m_state)
            0: if (mem_req && !mem_ready) begin m_state = 1; m_waited = 0; end
            1: begin
                if (mem_ready) m_state = 0;
                else begin
                    m_waited++;
                    if (m_waited >= WAIT_MAX) begin m_state = 2; m_tout = 1; end
                end
            end
            default: if (mem_ready) m_state = 0;
        endcase
    endtask

    task automatic drive(input vec_t v);
        Rs_ID = v.rs; Rt_ID = v.rt; PCSrc_ID = v.pid; MemRd_ID_EX = v.memrd;
        Rt_ID_EX = v.rtex; PCSrc_ID_EX = v.pex; ALUOut0_EX = v.alu;
        mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance through the edge.
    task automatic step(input vec_t v, input bit use_tbl);
        drive(v);
        #3;
        check("ctl", 32'(ctl), 32'(m_ctl()));
        check("state", 32'(state), 32'(m_state));
        check("mem_timeout", 32'(mem_timeout), 32'(m_tout));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall % (1 << CNT_W)));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush % (1 << CNT_W)));
        if (use_tbl) begin
            check("tbl_ctl", 32'(ctl), 32'(v.exp_ctl));
            check("tbl_stall", 32'(stall_cnt), 32'(v.exp_stall));
            check("tbl_flush", 32'(flush_cnt), 32'(v.exp_flush));
        end
        @(posedge clk);
        #1;
        model_edge();
    endtask

    vec_t tbl[16];
    vec_t v;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, 0, 0);
        tbl[1]  = mk(5, 1, 0, 1, 5, 0, 0, 0, 0, C_S, 0, 0);
        tbl[2]  = mk(5, 1, 0, 0, 0, 0, 0, 0, 0, C_N, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, C_N, 1, 0);
        tbl[4]  = mk(3, 7, 0, 1, 7, 1, 1, 0, 0, C_B, 1, 0);
        tbl[5]  = mk(7, 2, 0, 1, 7, 1, 0, 0, 0, C_S, 1, 1);
        tbl[6]  = mk(1, 2, 2, 0, 0, 0, 0, 0, 0, C_J, 2, 1);
        tbl[7]  = mk(1, 2, 3, 0, 0, 0, 0, 0, 0, C_J, 2, 2);
        tbl[8]  = mk(1, 2, 4, 0, 0, 0, 0, 0, 0, C_J, 2, 3);
        tbl[9]  = mk(1, 2, 5, 0, 0, 0, 0, 0, 0, C_J, 2, 4);
        tbl[10] = mk(1, 2, 6, 0, 0, 0, 0, 0, 0, C_N, 2, 5);
        tbl[11] = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, C_N, 2, 5);
        tbl[12] = mk(9, 4, 2, 1, 4, 0, 0, 0, 0, C_S, 2, 5);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 1, 1, 1, C_B, 3, 5);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, 3, 6);
        tbl[15] = mk(0, 0, 7, 0, 0, 1, 0, 0, 0, C_N, 3, 6);

        // Reset state, with hazard inputs active to show controls stay idle.
        model_reset();
        drive(mk(5, 5, 2, 1, 5, 1, 1, 1, 0, C_N, 0, 0));
        repeat (2) @(posedge clk);
        #3;
        check("rst_ctl", 32'(ctl), 32'(C_N));
        check("rst_state", 32'(state), 0);
        check("rst_timeout", 32'(mem_timeout), 0);
        check("rst_stall", 32'(stall_cnt), 0);
        check("rst_flush", 32'(flush_cnt), 0);
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, 0, 0));
        reset = 1'b1;

        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Memory wait with a pending taken branch: no flush until RUN.
        v = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, C_N, 0, 0);
        for (int i = 0; i < 3; i++) step(v, 1'b0);
        check("wait_state", 32'(state), 1);
        check("wait_pc_write", 32'(PC_write), 0);
        check("wait_flush_cnt", 32'(flush_cnt), 6);
        v.mrdy = 1'b1;
        step(v, 1'b0);
        check("wait_release_state", 32'(state), 0);
        check("wait_release_flush", 32'(flush_cnt), 6);
        v.mreq = 1'b0;
        v.mrdy = 1'b0;
        step(v, 1'b0);
        check("post_wait_flush", 32'(flush_cnt), 7);

        // Watchdog expiry, sticky flag, then async reset mid-wait.
        v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_N, 0, 0);
        for (int i = 0; i < WAIT_MAX; i++) step(v, 1'b0);
        check("pre_tout_state", 32'(state), 1);
        check("pre_tout_flag", 32'(mem_timeout), 0);
        step(v, 1'b0);
        check("tout_state", 32'(state), 2);
        check("tout_flag", 32'(mem_timeout), 1);
        step(v, 1'b0);
        check("tout_hold", 32'(state), 2);
        v.mrdy = 1'b1;
        step(v, 1'b0);
        check("tout_release_state", 32'(state), 0);
        check("tout_sticky", 32'(mem_timeout), 1);
        v.mrdy = 1'b0;
        step(v, 1'b0);
        step(v, 1'b0);
        check("midwait_state", 32'(state), 1);
        reset = 1'b0;
        #2;
        check("async_state", 32'(state), 0);
        check("async_timeout", 32'(mem_timeout), 0);
        check("async_stall", 32'(stall_cnt), 0);
        check("async_flush", 32'(flush_cnt), 0);
        check("async_ctl", 32'(ctl), 32'(C_N));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Counter wrap: 260 jump flushes on an 8-bit counter.
        v = mk(0, 0, 2, 0, 0, 0, 0, 0, 0, C_N, 0, 0);
        for (int i = 0; i < 260; i++) step(v, 1'b0);
        check("wrap_flush", 32'(flush_cnt), 4);

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 1) != 0) ? 1 : $urandom_range(0, 7),
                   $urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? 1 : 0,
                   $urandom_range(0, 1), C_N, 0, 0);
            step(v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
